exu_mem_req: RTL

Parametrised memory-request issuer for the execute stage. It decouples the execute stage from the AXI address/data channels through a DEPTH-entry request queue. It supports XLEN of 32 or 64 and independent AW/W handshakes (either channel may complete first). It generates size/strobe/lane-shifted write data and resolves misaligned accesses as exceptions without issuing them on AXI.

---
 rtl/exu_mem_req.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/exu_mem_req.sv
// Execute-stage memory-request issuer: DEPTH-entry queue feeding AXI AR/AW/W, with misalign faults.
// Optional EXU_MEM_REQ_PERF_EN adds saturating stall/full counters reported once per done_o.
module exu_mem_req #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_re_i,
  input  logic                       req_we_i,
  input  logic [1:0]                 req_size_i,
  input  logic [ADDR_W-1:0]          req_addr_i,
  input  logic [XLEN-1:0]            req_wdata_i,
  output logic                       arvalid_o,
  input  logic                       arready_i,
  output logic [ADDR_W-1:0]          araddr_o,
  output logic [2:0]                 arsize_o,
  output logic                       awvalid_o,
  input  logic                       awready_i,
  output logic [ADDR_W-1:0]          awaddr_o,
  output logic [2:0]                 awsize_o,
  output logic                       wvalid_o,
  input  logic                       wready_i,
  output logic [XLEN-1:0]            wdata_o,
  output logic [XLEN/8-1:0]          wstrb_o,
  output logic                       done_o,
  output logic                       excp_valid_o,
  output logic                       excp_store_o,
  output logic [ADDR_W-1:0]          excp_addr_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE_R, ISSUE_W, FAULT} state_t;

  logic              q_we    [DEPTH];
  logic              q_mis   [DEPTH];
  logic [1:0]        q_size  [DEPTH];
  logic [ADDR_W-1:0] q_addr  [DEPTH];
  logic [XLEN-1:0]   q_wdata [DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
  logic [CW-1:0] count, count_n;
  state_t        state, state_n;
  logic          aw_done, w_done, aw_done_n, w_done_n;

  logic hs_ar, hs_aw, hs_w, pop_w, pop, keep, push, push_mis;
  logic nh_we, nh_mis;

  logic              h_we;
  logic [1:0]        h_size;
  logic [ADDR_W-1:0] h_addr;
  logic [XLEN-1:0]   h_wdata;

  assign h_we    = q_we[rd_ptr];
  assign h_size  = q_size[rd_ptr];
  assign h_addr  = q_addr[rd_ptr];
  assign h_wdata = q_wdata[rd_ptr];

  assign req_ready_o = (count != CW'(DEPTH));
  assign count_o     = count;

  always_comb begin
    push_mis = 1'b0;
    unique case (req_size_i)
      2'd0:    push_mis = 1'b0;
      2'd1:    push_mis = req_addr_i[0];
      2'd2:    push_mis = |req_addr_i[1:0];
      default: push_mis = (|req_addr_i[2:0]) || (XLEN == 32);
    endcase
  end

  always_comb begin
    hs_ar = (state == ISSUE_R) && arready_i;
    hs_aw = (state == ISSUE_W) && !aw_done && awready_i;
    hs_w  = (state == ISSUE_W) && !w_done && wready_i;
    pop_w = (state == ISSUE_W) && (aw_done || hs_aw) && (w_done || hs_w);
    pop   = hs_ar || pop_w || (state == FAULT);
    // A store with any channel already accepted cannot be retracted, so flush keeps it.
    keep  = (state == ISSUE_W) && !pop_w && (aw_done || w_done || hs_aw || hs_w);
    push  = req_valid_i && req_ready_o && (req_re_i || req_we_i) && !flush_i;
  end

  always_comb begin
    rd_ptr_n  = rd_ptr;
    wr_ptr_n  = wr_ptr;
    count_n   = count;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    nh_we     = 1'b0;
    nh_mis    = 1'b0;
    state_n   = IDLE;
    if (flush_i) begin
      if (keep) begin
        wr_ptr_n  = rd_ptr + PW'(1);
        count_n   = CW'(1);
        aw_done_n = aw_done || hs_aw;
        w_done_n  = w_done || hs_w;
      end else begin
        wr_ptr_n  = rd_ptr;
        count_n   = '0;
        aw_done_n = 1'b0;
        w_done_n  = 1'b0;
      end
    end else begin
      rd_ptr_n = rd_ptr + PW'(pop);
      wr_ptr_n = wr_ptr + PW'(push);
      count_n  = count + CW'(push) - CW'(pop);
      if (pop) begin
        aw_done_n = 1'b0;
        w_done_n  = 1'b0;
      end else begin
        aw_done_n = aw_done || hs_aw;
        w_done_n  = w_done || hs_w;
      end
    end
    // The next head may be the entry being written this very cycle.
    if (push && (wr_ptr == rd_ptr_n)) begin
      nh_we  = req_we_i;
      nh_mis = push_mis;
    end else begin
      nh_we  = q_we[rd_ptr_n];
      nh_mis = q_mis[rd_ptr_n];
    end
    if (count_n == '0)  state_n = IDLE;
    else if (nh_mis)    state_n = FAULT;
    else if (nh_we)     state_n = ISSUE_W;
    else                state_n = ISSUE_R;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_n;
      rd_ptr  <= rd_ptr_n;
      wr_ptr  <= wr_ptr_n;
      count   <= count_n;
      aw_done <= aw_done_n;
      w_done  <= w_done_n;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_we[wr_ptr]    <= req_we_i;
      q_mis[wr_ptr]   <= push_mis;
      q_size[wr_ptr]  <= req_size_i;
      q_addr[wr_ptr]  <= req_addr_i;
      q_wdata[wr_ptr] <= req_wdata_i;
    end
  end

  logic [7:0]      m8;
  logic [NB-1:0]   bmask;
  logic [XLEN-1:0] dmask;
  logic [OW-1:0]   off;
  logic            head;

  always_comb begin
    unique case (h_size)
      2'd0:    m8 = 8'h01;
      2'd1:    m8 = 8'h03;
      2'd2:    m8 = 8'h0F;
      default: m8 = 8'hFF;
    endcase
    bmask = m8[NB-1:0];
    dmask = '0;
    for (int unsigned i = 0; i < NB; i++) dmask[8*i +: 8] = {8{bmask[i]}};
    off  = h_addr[OW-1:0];
    head = (state != IDLE);
  end

  always_comb begin
    arvalid_o    = (state == ISSUE_R);
    awvalid_o    = (state == ISSUE_W) && !aw_done;
    wvalid_o     = (state == ISSUE_W) && !w_done;
    araddr_o     = head ? h_addr : '0;
    awaddr_o     = head ? h_addr : '0;
    arsize_o     = head ? {1'b0, h_size} : '0;
    awsize_o     = head ? {1'b0, h_size} : '0;
    wstrb_o      = head ? (bmask << off) : '0;
    wdata_o      = head ? ((h_wdata & dmask) << {off, 3'b000}) : '0;
    done_o       = hs_ar || pop_w;
    excp_valid_o = (state == FAULT) && !flush_i;
    excp_store_o = excp_valid_o && h_we;
    excp_addr_o  = excp_valid_o ? h_addr : '0;
  end

`ifdef EXU_MEM_REQ_PERF_EN
  logic [31:0] stall_cnt, full_cnt;
  logic        stalled, blocked;

  assign stalled = (arvalid_o && !arready_i) || (awvalid_o && !awready_i) || (wvalid_o && !wready_i);
  assign blocked = req_valid_i && !req_ready_o;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      full_cnt  <= '0;
    end else begin
      if (stalled && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (blocked && (full_cnt != '1))  full_cnt  <= full_cnt + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (done_o) $display("exu_mem_req_perf stall=%0d full=%0d", stall_cnt, full_cnt);
  end
`else
  // Counters compiled out; ports and timing unchanged.
`endif

endmodule
